sprite_line_scheduler: RTL and testbench

//  Per-scanline sequencer for the 16x16 2-bit static sprite memory. On line_start it walks the

---
 rtl/sprite_pkg.sv | 25 ++
 rtl/sprite_hit_eval.sv | 28 ++
 rtl/sprite_line_scheduler.sv | 166 ++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, attribute field layout and FSM encoding for the sprite line scheduler.
package sprite_pkg;

  localparam int unsigned SPR_SIZE     = 16;
  localparam logic [1:0]  TRANSPARENT  = 2'b00;

  localparam int unsigned ATTR_W       = 27;
  localparam int unsigned ATTR_EN_BIT  = 26;
  localparam int unsigned ATTR_SEL_LSB = 20;
  localparam int unsigned ATTR_SEL_W   = 6;
  localparam int unsigned ATTR_SX_LSB  = 10;
  localparam int unsigned ATTR_SX_W    = 10;
  localparam int unsigned ATTR_SY_LSB  = 0;
  localparam int unsigned ATTR_SY_W    = 10;

  typedef enum logic [2:0] {
    StIdle,
    StAttr,
    StEval,
    StFetch,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/sprite_hit_eval.sv
// Combinational decode of one attribute entry against the line being rendered.
module sprite_hit_eval
  import sprite_pkg::*;
#(
  parameter int unsigned X_W = 10,
  parameter int unsigned Y_W = 10
) (
  input  logic [ATTR_W-1:0]     i_attr_data,
  input  logic [Y_W-1:0]        i_line_y,
  output logic                  o_hit,
  output logic [3:0]            o_row,
  output logic [ATTR_SEL_W-1:0] o_select,
  output logic [X_W-1:0]        o_sx
);

  logic [Y_W-1:0] w_sy;
  logic [Y_W-1:0] w_row;

  assign w_sy  = Y_W'(i_attr_data[ATTR_SY_LSB +: ATTR_SY_W]);
  // Modular subtraction: sprites placed near the bottom wrap onto the top lines.
  assign w_row = i_line_y - w_sy;

  assign o_hit    = i_attr_data[ATTR_EN_BIT] && (w_row < Y_W'(SPR_SIZE));
  assign o_row    = w_row[3:0];
  assign o_select = i_attr_data[ATTR_SEL_LSB +: ATTR_SEL_W];
  assign o_sx     = X_W'(i_attr_data[ATTR_SX_LSB +: ATTR_SX_W]);

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite sequencer: walks the attribute table and copies visible sprite pixels
// into the next-line buffer. Optional per-line sprite limit enabled by SPRITE_LINE_LIMIT_EN.
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES  = 16,
  parameter int unsigned X_W          = 10,
  parameter int unsigned Y_W          = 10,
  parameter int unsigned LINE_W       = 640,
  parameter int unsigned MAX_PER_LINE = 8
) (
  input  logic           i_clock,
  input  logic           i_resetn,
  input  logic           i_line_start,
  input  logic [Y_W-1:0] i_line_y,
  output logic           o_busy,
  output logic           o_done,
  output logic [5:0]     o_attr_addr,
  input  logic [26:0]    i_attr_data,
  output logic [5:0]     o_spr_select,
  output logic [3:0]     o_spr_x,
  output logic [3:0]     o_spr_y,
  input  logic [1:0]     i_spr_pix,
  output logic           o_lb_we,
  output logic [X_W-1:0] o_lb_addr,
  output logic [1:0]     o_lb_data
`ifdef SPRITE_LINE_LIMIT_EN
  ,
  output logic           o_line_ovf
`endif
);

  state_e         r_state, w_state_d;
  logic [Y_W-1:0] r_line_y;
  logic [5:0]     r_idx;
  logic [X_W-1:0] r_sx;
  logic [5:0]     r_spr_select;
  logic [3:0]     r_spr_x;
  logic [3:0]     r_spr_y;
  logic           r_wr_vld;
  logic [3:0]     r_wr_col;

  logic           w_hit;
  logic           w_take;
  logic           w_last;
  logic [3:0]     w_row;
  logic [5:0]     w_select;
  logic [X_W-1:0] w_sx;
  logic [X_W:0]   w_px;
  logic           w_wr;

  sprite_hit_eval #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_hit_eval (
    .i_attr_data (i_attr_data),
    .i_line_y    (r_line_y),
    .o_hit       (w_hit),
    .o_row       (w_row),
    .o_select    (w_select),
    .o_sx        (w_sx)
  );

  assign w_last = (r_idx == 6'(NUM_SPRITES - 1));

`ifdef SPRITE_LINE_LIMIT_EN
  logic [6:0] r_hit_cnt;
  logic       r_line_ovf;

  // Hits beyond the per-line budget behave as misses but are remembered in line_ovf.
  assign w_take = w_hit && (r_hit_cnt < 7'(MAX_PER_LINE));

  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_hit_cnt  <= '0;
      r_line_ovf <= 1'b0;
    end else if (r_state == StIdle && i_line_start) begin
      r_hit_cnt  <= '0;
      r_line_ovf <= 1'b0;
    end else if (r_state == StEval && w_hit) begin
      if (w_take) r_hit_cnt <= r_hit_cnt + 7'd1;
      else        r_line_ovf <= 1'b1;
    end
  end

  assign o_line_ovf = r_line_ovf;
`else
  assign w_take = w_hit;
`endif

  always_ff @(posedge i_clock) begin
    if (!i_resetn) r_state <= StIdle;
    else           r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (i_line_start) w_state_d = StAttr;
      StAttr:  w_state_d = StEval;
      StEval: begin
        if (w_take)      w_state_d = StFetch;
        else if (w_last) w_state_d = StDone;
        else             w_state_d = StAttr;
      end
      StFetch: if (r_spr_x == 4'hf) w_state_d = StDrain;
      StDrain: w_state_d = w_last ? StDone : StAttr;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_line_y     <= '0;
      r_idx        <= '0;
      r_sx         <= '0;
      r_spr_select <= '0;
      r_spr_x      <= '0;
      r_spr_y      <= '0;
      r_wr_vld     <= 1'b0;
      r_wr_col     <= '0;
    end else begin
      // Pixel for the column issued this cycle returns next cycle, so track it one behind.
      r_wr_vld <= (r_state == StFetch);
      r_wr_col <= r_spr_x;
      unique case (r_state)
        StIdle: begin
          if (i_line_start) begin
            r_line_y <= i_line_y;
            r_idx    <= '0;
          end
        end
        StEval: begin
          if (w_take) begin
            r_sx         <= w_sx;
            r_spr_select <= w_select;
            r_spr_y      <= w_row;
            r_spr_x      <= '0;
          end else if (!w_last) begin
            r_idx <= r_idx + 6'd1;
          end
        end
        StFetch: r_spr_x <= r_spr_x + 4'd1;
        StDrain: if (!w_last) r_idx <= r_idx + 6'd1;
        default: ;
      endcase
    end
  end

  assign w_px = (X_W+1)'(r_sx) + (X_W+1)'(r_wr_col);
  // Reset gates the write port combinationally so nothing lands during the reset cycle.
  assign w_wr = r_wr_vld && i_resetn;

  assign o_lb_we   = w_wr && (i_spr_pix != TRANSPARENT) && (w_px < (X_W+1)'(LINE_W));
  assign o_lb_addr = w_wr ? w_px[X_W-1:0] : '0;
  assign o_lb_data = w_wr ? i_spr_pix : TRANSPARENT;

  assign o_busy       = (r_state != StIdle);
  assign o_done       = (r_state == StDone);
  assign o_attr_addr  = r_idx;
  assign o_spr_select = r_spr_select;
  assign o_spr_x      = r_spr_x;
  assign o_spr_y      = r_spr_y;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Randomized self-checking bench for sprite_line_scheduler against a line-level painter model.
module tb_sprite_line_scheduler;

  localparam int NS    = 4;
  localparam int LW    = 640;
  localparam int MAXPL = 2;
  localparam int BOUND = 300;

  typedef struct packed {
    logic [9:0] a;
    logic [1:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       line_start = 1'b0;
  logic [9:0] line_y = '0;
  logic       busy, done, lb_we;
  logic [5:0] attr_addr, spr_select;
  logic [3:0] spr_x, spr_y;
  logic [26:0] attr_q = '0;
  logic [1:0] pix_q = '0;
  logic [9:0] lb_addr;
  logic [1:0] lb_data;
`ifdef SPRITE_LINE_LIMIT_EN
  logic       line_ovf;
`endif

  logic [26:0] attr_mem [0:63];
  logic [1:0]  smem [0:63][0:15][0:15];
  logic [1:0]  lbuf [0:1023];
  logic [1:0]  mbuf [0:1023];
  wr_t         exp_q [$];
  wr_t         mon_e;
  int          mon_wcnt = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  sprite_line_scheduler #(
    .NUM_SPRITES  (NS),
    .X_W          (10),
    .Y_W          (10),
    .LINE_W       (LW),
    .MAX_PER_LINE (MAXPL)
  ) dut (
    .i_clock      (clk),
    .i_resetn     (resetn),
    .i_line_start (line_start),
    .i_line_y     (line_y),
    .o_busy       (busy),
    .o_done       (done),
    .o_attr_addr  (attr_addr),
    .i_attr_data  (attr_q),
    .o_spr_select (spr_select),
    .o_spr_x      (spr_x),
    .o_spr_y      (spr_y),
    .i_spr_pix    (pix_q),
    .o_lb_we      (lb_we),
    .o_lb_addr    (lb_addr),
    .o_lb_data    (lb_data)
`ifdef SPRITE_LINE_LIMIT_EN
    ,
    .o_line_ovf   (line_ovf)
`endif
  );

  // Synchronous-read attribute table and sprite memory.
  always @(posedge clk) begin
    attr_q <= attr_mem[attr_addr];
    pix_q  <= smem[spr_select][spr_y][spr_x];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
  endtask

  // Every line-buffer write must be the next one the model predicts.
  always @(negedge clk) begin
    if (lb_we) begin
      mon_wcnt++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got addr %0d data %0d, required no write", lb_addr,
                 lb_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("lb_write", {20'd0, lb_addr, lb_data}, {20'd0, mon_e.a, mon_e.d});
      end
      lbuf[lb_addr] = lb_data;
    end
  end

  task automatic build_model(input logic [9:0] y, output int hits, output bit ovf);
    logic [26:0] a;
    logic [9:0]  row;
    logic [1:0]  p;
    int          px;
    hits = 0;
    ovf  = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 1024; i++) mbuf[i] = 2'd0;
    for (int i = 0; i < NS; i++) begin
      a   = attr_mem[i];
      row = y - a[9:0];
      if (a[26] && row < 10'd16) begin
`ifdef SPRITE_LINE_LIMIT_EN
        if (hits >= MAXPL) begin
          ovf = 1'b1;
          continue;
        end
`endif
        hits++;
        for (int c = 0; c < 16; c++) begin
          p  = smem[a[25:20]][row[3:0]][c];
          px = int'(a[19:10]) + c;
          if (p != 2'd0 && px < LW) begin
            exp_q.push_back(wr_t'{px[9:0], p});
            mbuf[px] = p;
          end
        end
      end
    end
  endtask

  task automatic render(input logic [9:0] y, output int cyc);
    int hits;
    bit ovf;
    int low_busy;
    int diffs;
    build_model(y, hits, ovf);
    for (int i = 0; i < 1024; i++) lbuf[i] = 2'd0;
    mon_wcnt = 0;
    @(negedge clk);
    line_y     = y;
    line_start = 1'b1;
    cyc        = 0;
    low_busy   = 0;
    do begin
      @(negedge clk);
      line_start = 1'b0;
      cyc++;
      if (!busy) low_busy++;
`ifdef SPRITE_LINE_LIMIT_EN
      if (cyc == 1) check("ovf_cleared_on_start", line_ovf, 0);
`endif
    end while (!done && cyc < BOUND);
    check("cycles_to_done", cyc, 2 * NS + 17 * hits + 1);
    check("busy_during_line", low_busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("pending_writes", exp_q.size(), 0);
    diffs = 0;
    for (int i = 0; i < 1024; i++) if (lbuf[i] !== mbuf[i]) diffs++;
    check("linebuf_diffs", diffs, 0);
`ifdef SPRITE_LINE_LIMIT_EN
    check("line_ovf", line_ovf, ovf);
`endif
  endtask

  initial begin
    int cyc;
    int hits;
    bit ovf;
    int waited;
    logic [9:0] ry, rsx, rsy;
    logic [5:0] rsel;
    logic       ren;

    for (int s = 0; s < 64; s++)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) smem[s][r][c] = 2'($urandom);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        smem[5][r][c] = 2'(c % 4);
        smem[6][r][c] = (r == 7) ? 2'd2 : 2'd1;
        smem[7][r][c] = 2'd1;
        smem[8][r][c] = 2'd3;
        smem[9][r][c] = 2'd2;
      end
    for (int i = 0; i < 64; i++) attr_mem[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lb_we", lb_we, 0);
    check("rst_attr_addr", attr_addr, 0);
    check("rst_spr", {spr_select, spr_x, spr_y}, 0);
    check("rst_lb_addr_data", {lb_addr, lb_data}, 0);
    resetn = 1'b1;

    // All sprites disabled.
    render(10'd10, cyc);
    check("t1_cycles_literal", cyc, 9);
    check("t1_no_writes", mon_wcnt, 0);

    // Column-pattern sprite, skips transparent columns.
    attr_mem[0] = {1'b1, 6'd5, 10'd100, 10'd50};
    render(10'd53, cyc);
    check("t2_cycles_literal", cyc, 26);
    check("t2_write_count", mon_wcnt, 12);
    check("t2_x100", lbuf[100], 0);
    check("t2_x101", lbuf[101], 1);
    check("t2_x104", lbuf[104], 0);
    check("t2_x107", lbuf[107], 3);

    // Right-edge clipping, then vertical wrap.
    attr_mem[0] = {1'b1, 6'd5, 10'd630, 10'd50};
    render(10'd60, cyc);
    check("t3_clip_count", mon_wcnt, 7);
    check("t3_x639", lbuf[639], 1);
    attr_mem[0] = {1'b1, 6'd6, 10'd300, 10'd1020};
    render(10'd3, cyc);
    check("t3_wrap_row7", lbuf[300], 2);

    // Overlap: later index wins.
    attr_mem[0] = {1'b1, 6'd7, 10'd190, 10'd50};
    attr_mem[1] = {1'b1, 6'd8, 10'd200, 10'd50};
    render(10'd55, cyc);
    check("t4_overlap_x200", lbuf[200], 3);
    check("t4_x195", lbuf[195], 1);
    check("t4_x215", lbuf[215], 3);

    // Reset in the middle of FETCH column 5, then a full line.
    attr_mem[1] = '0;
    build_model(10'd55, hits, ovf);
    @(negedge clk);
    line_y     = 10'd55;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    waited = 0;
    while (!(busy && spr_x == 4'd5) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("t5_reached_col5", waited < 100, 1);
    resetn = 1'b0;
    #1;
    check("t5_no_write_in_reset", lb_we, 0);
    @(negedge clk);
    check("t5_busy_after_reset", busy, 0);
    check("t5_we_after_reset", lb_we, 0);
    check("t5_addr_after_reset", attr_addr, 0);
    resetn = 1'b1;
    exp_q.delete();
    render(10'd55, cyc);
    check("t5_rerender_cycles", cyc, 26);

    // Three hits on one line; limited build draws only two.
    attr_mem[0] = {1'b1, 6'd7, 10'd100, 10'd50};
    attr_mem[1] = {1'b1, 6'd8, 10'd150, 10'd50};
    attr_mem[2] = {1'b1, 6'd9, 10'd200, 10'd50};
    render(10'd52, cyc);
`ifdef SPRITE_LINE_LIMIT_EN
    check("t6_third_dropped", lbuf[200], 0);
    check("t6_ovf_set", line_ovf, 1);
`else
    check("t6_third_drawn", lbuf[200], 2);
`endif
    for (int i = 0; i < NS; i++) attr_mem[i] = '0;
    render(10'd500, cyc);
`ifdef SPRITE_LINE_LIMIT_EN
    check("t6_ovf_cleared", line_ovf, 0);
`endif

    // Random attribute tables and lines.
    for (int n = 0; n < 25; n++) begin
      ry = 10'($urandom_range(0, 1023));
      for (int i = 0; i < NS; i++) begin
        ren  = ($urandom_range(0, 3) != 0);
        rsel = 6'($urandom_range(0, 63));
        rsx  = 10'($urandom_range(0, 1023));
        rsy  = ry - 10'($urandom_range(0, 24));
        attr_mem[i] = {ren, rsel, rsx, rsy};
      end
      render(ry, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
